sal_bk_ctrl: RTL and testbench



---
 rtl/sal_bk_ctrl_pkg.sv | 29 ++
 rtl/sal_bk_timer.sv | 25 ++
 rtl/sal_bk_ctrl.sv | 161 ++++++++++++++++
 tb/tb_sal_bk_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sal_bk_ctrl_pkg.sv
// Shared definitions for the SAL DDR2 per-bank controller: bank count, address/tag widths,
// DDR2-800 timing defaults and the bank state encoding.
package sal_bk_ctrl_pkg;

    localparam int DRAM_BK_CNT  = 4;
    localparam int DRAM_ROW_W   = 14;
    localparam int DRAM_COL_W   = 10;
    localparam int DRAM_ID_W    = 4;

    localparam int DRAM_T_RCD   = 5;
    localparam int DRAM_T_RAS   = 18;
    localparam int DRAM_T_RTP   = 3;
    localparam int DRAM_T_WTP   = 14;
    localparam int DRAM_T_RP    = 5;

    localparam int CNT_W        = 5;

    typedef enum logic [1:0] {
        BK_IDLE      = 2'd0,
        BK_ACTIVE    = 2'd1,
        BK_PRECHARGE = 2'd2
    } bk_state_t;

    function automatic logic [CNT_W-1:0] cnt_max(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sal_bk_timer.sv
// 5-bit timing counter: loads a value, then counts down to zero and holds there.
module sal_bk_timer
    import sal_bk_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] cnt,
    output logic             is_zero
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign is_zero = (cnt == '0);

endmodule

// File: rtl/sal_bk_ctrl.sv
// Per-bank DDR2 controller: single-entry request buffer, open-page row tracking and
// per-bank tRCD/tRAS/tRTP/tWTP/tRP gating of ACT/PRE/RD/WR requests to the scheduler.
module sal_bk_ctrl
    import sal_bk_ctrl_pkg::*;
#(
    parameter int ROW_W = DRAM_ROW_W,
    parameter int COL_W = DRAM_COL_W,
    parameter int ID_W  = DRAM_ID_W,
    parameter int T_RCD = DRAM_T_RCD,
    parameter int T_RAS = DRAM_T_RAS,
    parameter int T_RTP = DRAM_T_RTP,
    parameter int T_WTP = DRAM_T_WTP,
    parameter int T_RP  = DRAM_T_RP
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_wr,
    input  logic [ROW_W-1:0]   req_row,
    input  logic [COL_W-1:0]   req_col,
    input  logic [ID_W-1:0]    req_id,
    output logic               act_req,
    output logic               pre_req,
    output logic               rd_req,
    output logic               wr_req,
    output logic [ROW_W-1:0]   cmd_row,
    output logic [COL_W-1:0]   cmd_col,
    output logic [ID_W-1:0]    cmd_id,
    input  logic               act_gnt,
    input  logic               pre_gnt,
    input  logic               rd_gnt,
    input  logic               wr_gnt,
    output logic [1:0]         dbg_state,
    output logic [4*CNT_W-1:0] dbg_cnt
);

    localparam logic [CNT_W-1:0] RCD_LD = CNT_W'(T_RCD - 1);
    localparam logic [CNT_W-1:0] RAS_LD = CNT_W'(T_RAS - 1);
    localparam logic [CNT_W-1:0] RTP_LD = CNT_W'(T_RTP - 1);
    localparam logic [CNT_W-1:0] WTP_LD = CNT_W'(T_WTP - 1);
    localparam logic [CNT_W-1:0] RP_LD  = CNT_W'(T_RP - 1);

    bk_state_t          state_q, state_d;
    logic               buf_valid, buf_wr, rdy_en;
    logic [ROW_W-1:0]   buf_row, open_row;
    logic [COL_W-1:0]   buf_col;
    logic [ID_W-1:0]    buf_id;
    logic               accept, row_hit;
    logic               act_fire, pre_fire, cas_fire;
    logic               ld_rcd, ld_ras, ld_pre, ld_rp;
    logic [CNT_W-1:0]   pre_ld_val;
    logic [CNT_W-1:0]   cnt_rcd, cnt_ras, cnt_pre, cnt_rp;
    logic               rcd_zero, ras_zero, pre_zero, rp_zero;

    // Upstream handshake: a request transfers in any cycle where req_valid and req_ready are
    // both high; req_ready comes only from registers, so grants never reach it combinationally.
    // Scheduler handshake: a *_req stays high with cmd_* stable until its own *_gnt in the
    // same cycle; a grant arriving without its request is ignored.
    assign req_ready = rdy_en & ~buf_valid;
    assign accept    = req_valid & req_ready;
    assign row_hit   = (buf_row == open_row);

    assign cmd_row   = buf_row;
    assign cmd_col   = buf_col;
    assign cmd_id    = buf_id;
    assign dbg_state = state_q;
    assign dbg_cnt   = {cnt_rcd, cnt_ras, cnt_pre, cnt_rp};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BK_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        act_req    = 1'b0;
        pre_req    = 1'b0;
        rd_req     = 1'b0;
        wr_req     = 1'b0;
        case (state_q)
            BK_IDLE: begin
                act_req = buf_valid;
            end
            BK_ACTIVE: begin
                if (buf_valid) begin
                    if (row_hit) begin
                        rd_req = rcd_zero & ~buf_wr;
                        wr_req = rcd_zero &  buf_wr;
                    end else begin
                        pre_req = ras_zero & pre_zero;
                    end
                end
            end
            BK_PRECHARGE: begin
                if (rp_zero) begin
                    act_req = buf_valid;
                    state_d = BK_IDLE;
                end
            end
            default: begin
                state_d = BK_IDLE;
            end
        endcase

        act_fire   = act_req & act_gnt;
        pre_fire   = pre_req & pre_gnt;
        cas_fire   = (rd_req & rd_gnt) | (wr_req & wr_gnt);
        ld_rcd     = act_fire;
        ld_ras     = act_fire;
        ld_rp      = pre_fire;
        ld_pre     = cas_fire;
        // A later CAS may only extend the precharge hold-off, never shorten it.
        pre_ld_val = buf_wr ? cnt_max(cnt_pre, WTP_LD) : cnt_max(cnt_pre, RTP_LD);

        if (act_fire) begin
            state_d = BK_ACTIVE;
        end else if (pre_fire) begin
            state_d = BK_PRECHARGE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en    <= 1'b0;
            buf_valid <= 1'b0;
            buf_wr    <= 1'b0;
            buf_row   <= '0;
            buf_col   <= '0;
            buf_id    <= '0;
            open_row  <= '0;
        end else begin
            rdy_en <= 1'b1;
            if (accept) begin
                buf_valid <= 1'b1;
                buf_wr    <= req_wr;
                buf_row   <= req_row;
                buf_col   <= req_col;
                buf_id    <= req_id;
            end else if (cas_fire) begin
                buf_valid <= 1'b0;
            end
            if (act_fire) begin
                open_row <= buf_row;
            end
        end
    end

    sal_bk_timer u_rcd (.clk(clk), .rst_n(rst_n), .load(ld_rcd), .load_val(RCD_LD),
                        .cnt(cnt_rcd), .is_zero(rcd_zero));
    sal_bk_timer u_ras (.clk(clk), .rst_n(rst_n), .load(ld_ras), .load_val(RAS_LD),
                        .cnt(cnt_ras), .is_zero(ras_zero));
    sal_bk_timer u_pre (.clk(clk), .rst_n(rst_n), .load(ld_pre), .load_val(pre_ld_val),
                        .cnt(cnt_pre), .is_zero(pre_zero));
    sal_bk_timer u_rp  (.clk(clk), .rst_n(rst_n), .load(ld_rp),  .load_val(RP_LD),
                        .cnt(cnt_rp),  .is_zero(rp_zero));

endmodule

// File: tb/tb_sal_bk_ctrl.sv
// Directed bench for sal_bk_ctrl: cycle-time bank model checked every cycle, plus
// hand-computed latency checks for the documented scenarios.
module tb_sal_bk_ctrl;
    import sal_bk_ctrl_pkg::*;

    localparam int ROW_W = 14;
    localparam int COL_W = 10;
    localparam int ID_W  = 4;
    localparam int TB_RCD = 5;
    localparam int TB_RAS = 18;
    localparam int TB_RTP = 3;
    localparam int TB_WTP = 14;
    localparam int TB_RP  = 5;
    localparam int LIMIT  = 100;
    localparam int K_ACT = 0, K_PRE = 1, K_RD = 2, K_WR = 3;

    logic             clk, rst_n;
    logic             req_valid, req_ready, req_wr;
    logic [ROW_W-1:0] req_row, cmd_row;
    logic [COL_W-1:0] req_col, cmd_col;
    logic [ID_W-1:0]  req_id, cmd_id;
    logic             act_req, pre_req, rd_req, wr_req;
    logic             act_gnt, pre_gnt, rd_gnt, wr_gnt;
    logic [1:0]       dbg_state;
    logic [19:0]      dbg_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    sal_bk_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_row(req_row), .req_col(req_col), .req_id(req_id),
        .act_req(act_req), .pre_req(pre_req), .rd_req(rd_req), .wr_req(wr_req),
        .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_id(cmd_id),
        .act_gnt(act_gnt), .pre_gnt(pre_gnt), .rd_gnt(rd_gnt), .wr_gnt(wr_gnt),
        .dbg_state(dbg_state), .dbg_cnt(dbg_cnt)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // ---------------- bank model ----------------
    // Keeps event times (cycle numbers) and derives each command's earliest legal cycle.
    bit               m_buf_v, m_buf_wr, m_open, m_rdy_en;
    logic [ROW_W-1:0] m_buf_row, m_open_row;
    logic [COL_W-1:0] m_buf_col;
    logic [ID_W-1:0]  m_buf_id;
    int               m_act_cyc, m_pre_cyc, m_pre_ok;
    bit               e_act, e_pre, e_rd, e_wr, e_ready;

    always begin
        @(negedge clk);
        #3;
        if (!rst_n) begin
            m_buf_v = 0; m_open = 0; m_rdy_en = 0; m_open_row = '0;
            m_act_cyc = -1000; m_pre_cyc = -1000; m_pre_ok = -1000;
            chk("rst_reqs", {28'd0, act_req, pre_req, rd_req, wr_req}, 32'd0);
            chk("rst_ready", {31'd0, req_ready}, 32'd0);
            chk("rst_cmd", {4'd0, cmd_row, cmd_col, cmd_id}, 32'd0);
        end else begin
            e_act = 0; e_pre = 0; e_rd = 0; e_wr = 0;
            e_ready = m_rdy_en && !m_buf_v;
            if (m_buf_v) begin
                if (!m_open) begin
                    e_act = (cyc >= m_pre_cyc + TB_RP);
                end else if (m_buf_row == m_open_row) begin
                    if (cyc >= m_act_cyc + TB_RCD) begin
                        e_rd = !m_buf_wr;
                        e_wr = m_buf_wr;
                    end
                end else begin
                    e_pre = (cyc >= m_pre_ok);
                end
            end
            chk("req_ready", {31'd0, req_ready}, {31'd0, e_ready});
            chk("act_req", {31'd0, act_req}, {31'd0, e_act});
            chk("pre_req", {31'd0, pre_req}, {31'd0, e_pre});
            chk("rd_req",  {31'd0, rd_req},  {31'd0, e_rd});
            chk("wr_req",  {31'd0, wr_req},  {31'd0, e_wr});
            if (e_act || e_pre || e_rd || e_wr) begin
                chk("cmd_row", {18'd0, cmd_row}, {18'd0, m_buf_row});
                chk("cmd_id",  {28'd0, cmd_id},  {28'd0, m_buf_id});
                if (e_rd || e_wr) chk("cmd_col", {22'd0, cmd_col}, {22'd0, m_buf_col});
            end
            // effects of the coming clock edge
            if (e_act && act_gnt) begin
                m_open = 1; m_open_row = m_buf_row; m_act_cyc = cyc; m_pre_ok = cyc + TB_RAS;
            end
            if (e_pre && pre_gnt) begin
                m_open = 0; m_pre_cyc = cyc;
            end
            if ((e_rd && rd_gnt) || (e_wr && wr_gnt)) begin
                m_pre_ok = (m_pre_ok > cyc + (e_wr ? TB_WTP : TB_RTP)) ? m_pre_ok
                           : cyc + (e_wr ? TB_WTP : TB_RTP);
                m_buf_v = 0;
            end
            if (req_valid && e_ready) begin
                m_buf_v = 1; m_buf_wr = req_wr; m_buf_row = req_row;
                m_buf_col = req_col; m_buf_id = req_id;
            end
            m_rdy_en = 1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
        #1;
        req_valid = 1'b0;
        act_gnt = 1'b0; pre_gnt = 1'b0; rd_gnt = 1'b0; wr_gnt = 1'b0;
    endtask

    function automatic logic get_req(input int kind);
        case (kind)
            K_ACT:   return act_req;
            K_PRE:   return pre_req;
            K_RD:    return rd_req;
            default: return wr_req;
        endcase
    endfunction

    task automatic send(input logic wr, input logic [ROW_W-1:0] row,
                        input logic [COL_W-1:0] col, input logic [ID_W-1:0] id, output int a);
        a = -1;
        for (int i = 0; i < LIMIT; i++) begin
            tick();
            if (req_ready) begin
                req_valid = 1'b1; req_wr = wr; req_row = row; req_col = col; req_id = id;
                a = cyc;
                break;
            end
        end
        if (a < 0) chk("send_timeout", 32'd0, 32'd1);
    endtask

    // Waits for the request of the given kind and grants it in the same cycle.
    task automatic serve(input int kind, output int t);
        t = -1;
        for (int i = 0; i < LIMIT; i++) begin
            tick();
            if (get_req(kind)) begin
                case (kind)
                    K_ACT:   act_gnt = 1'b1;
                    K_PRE:   pre_gnt = 1'b1;
                    K_RD:    rd_gnt  = 1'b1;
                    default: wr_gnt  = 1'b1;
                endcase
                t = cyc;
                break;
            end
        end
        if (t < 0) chk("serve_timeout", kind, 32'hFF);
    endtask

    task automatic wait_req(input int kind, output int t);
        t = -1;
        for (int i = 0; i < LIMIT; i++) begin
            tick();
            if (get_req(kind)) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) chk("wait_timeout", kind, 32'hFF);
    endtask

    // ---------------- directed sequence ----------------
    int a, t_act, t_rd, t_wr, t_pre, t_a2, t_a3, t_x;

    initial begin
        rst_n = 1'b1;
        req_valid = 1'b0; req_wr = 1'b0; req_row = '0; req_col = '0; req_id = '0;
        act_gnt = 1'b0; pre_gnt = 1'b0; rd_gnt = 1'b0; wr_gnt = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) tick();
        chk("reset_state", {30'd0, dbg_state}, {30'd0, BK_IDLE});
        chk("reset_counters", {12'd0, dbg_cnt}, 32'd0);
        chk("reset_ready", {31'd0, req_ready}, 32'd0);
        tick();
        rst_n = 1'b1;
        chk("ready_at_release", {31'd0, req_ready}, 32'd0);
        tick();
        chk("ready_after_release", {31'd0, req_ready}, 32'd1);

        // closed bank read, row 0x12 col 0x40
        send(1'b0, 14'h12, 10'h40, 4'h1, a);
        serve(K_ACT, t_act);
        chk("act_after_accept", t_act - a, 32'd1);
        serve(K_RD, t_rd);
        chk("rd_after_act", t_rd - t_act, 32'd5);
        chk("rd_cmd_col", {22'd0, cmd_col}, 32'h40);

        // row hit: no ACT, read one cycle after accept
        send(1'b0, 14'h12, 10'h41, 4'h2, a);
        serve(K_RD, t_rd);
        chk("hit_rd_after_accept", t_rd - a, 32'd1);

        // write at ACT+20, then a miss to row 0x34
        while (cyc < t_act + 20) tick();
        send(1'b1, 14'h12, 10'h2A, 4'h3, a);
        serve(K_WR, t_wr);
        chk("wr_after_accept", t_wr - a, 32'd1);
        chk("wr_cmd_col", {22'd0, cmd_col}, 32'h2A);
        send(1'b0, 14'h34, 10'h10, 4'h4, a);
        serve(K_PRE, t_pre);
        chk("pre_after_wr", t_pre - t_wr, 32'd14);
        serve(K_ACT, t_a2);
        chk("act_after_pre", t_a2 - t_pre, 32'd5);
        chk("act_cmd_row", {18'd0, cmd_row}, 32'h34);
        serve(K_RD, t_rd);

        // reopen 0x12, read right after ACT, then miss: tRAS dominates tRTP
        send(1'b0, 14'h12, 10'h05, 4'h5, a);
        serve(K_PRE, t_pre);
        chk("pre_gated_by_ras", t_pre - t_a2, 32'd18);
        serve(K_ACT, t_a3);
        serve(K_RD, t_rd);
        chk("rd_right_after_act", t_rd - t_a3, 32'd5);
        send(1'b0, 14'h56, 10'h06, 4'h6, a);
        serve(K_PRE, t_pre);
        chk("pre_ras_not_rtp", t_pre - t_a3, 32'd18);
        serve(K_ACT, t_x);
        serve(K_RD, t_rd);

        // scheduler withholds act_gnt for 10 cycles, stray grants in between
        send(1'b0, 14'h77, 10'h07, 4'h9, a);
        serve(K_PRE, t_pre);
        wait_req(K_ACT, t_x);
        chk("hold_act_rise", t_x - t_pre, 32'd5);
        for (int k = 0; k < 10; k++) begin
            tick();
            if (k == 3) begin
                pre_gnt = 1'b1; rd_gnt = 1'b1; wr_gnt = 1'b1;
            end
            chk("hold_act_req", {31'd0, act_req}, 32'd1);
            chk("hold_cmd_row", {18'd0, cmd_row}, 32'h77);
            chk("hold_cmd_id", {28'd0, cmd_id}, 32'h9);
        end
        serve(K_ACT, t_x);
        serve(K_RD, t_rd);
        chk("hold_rd_after_act", t_rd - t_x, 32'd5);

        // reset two cycles after act_gnt
        send(1'b0, 14'h15, 10'h08, 4'hA, a);
        serve(K_PRE, t_pre);
        serve(K_ACT, t_x);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("async_rst_reqs", {28'd0, act_req, pre_req, rd_req, wr_req}, 32'd0);
        chk("async_rst_ready", {31'd0, req_ready}, 32'd0);
        chk("async_rst_state", {30'd0, dbg_state}, {30'd0, BK_IDLE});
        repeat (2) tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
        chk("post_rst_state", {30'd0, dbg_state}, {30'd0, BK_IDLE});
        send(1'b0, 14'h15, 10'h08, 4'hB, a);
        serve(K_ACT, t_x);
        chk("post_rst_fresh_act", t_x - a, 32'd1);
        serve(K_RD, t_rd);
        chk("post_rst_rd", t_rd - t_x, 32'd5);

        repeat (4) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
